// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-state controller.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2
  } state_t;

  localparam int GRID   = 16;
  localparam int CENTER = 7;
  localparam int LCOL   = 1;
  localparam int RCOL   = 14;

  // len consecutive ones starting at row pos.
  function automatic logic [GRID-1:0] paddle_mask(input logic [3:0] pos, input int len);
    logic [GRID-1:0] ones;
    ones = GRID'((32'd1 << len) - 32'd1);
    return ones << pos;
  endfunction

endpackage

// File: rtl/pong_if.sv
// Bundle between the game controller and its surroundings: sync/buttons in, display state out.
interface pong_if;
  import pong_pkg::*;

  logic        vsync;
  logic        lup;
  logic        ldown;
  logic        rup;
  logic        rdown;
  logic [3:0]  ball_x;
  logic [3:0]  ball_y;
  logic [15:0] lpaddle;
  logic [15:0] rpaddle;
  logic [3:0]  lscore;
  logic [3:0]  rscore;
  logic        step;
  state_t      state;

  // No handshake: every display output is valid at all times and only changes
  // on the clock edge that ends a step pulse; inputs are sampled continuously.
  modport game (
    input  vsync, lup, ldown, rup, rdown,
    output ball_x, ball_y, lpaddle, rpaddle, lscore, rscore, step, state
  );

  modport host (
    output vsync, lup, ldown, rup, rdown,
    input  ball_x, ball_y, lpaddle, rpaddle, lscore, rscore, step, state
  );

endinterface

// File: rtl/pong_step_timer.sv
// Vsync rise detector and frame divider producing the one-cycle game step pulse.
module pong_step_timer #(
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic step
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

  logic          vsync_q;
  logic          frame;
  logic [CW-1:0] frame_cnt;

  assign frame = vsync & ~vsync_q;

  // vsync_q resets high so a sync already high at release is not taken as a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q   <= 1'b1;
      frame_cnt <= '0;
      step      <= 1'b0;
    end else begin
      vsync_q <= vsync;
      step    <= 1'b0;
      if (frame) begin
        if (frame_cnt == LAST) begin
          frame_cnt <= '0;
          step      <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pong_game.sv
// Pong game-state controller: paddles, ball, scores and serve/play/scored FSM, advanced once per step.
module pong_game
  import pong_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 4,
  parameter int PADDLE_LEN      = 4,
  parameter int SERVE_STEPS     = 8,
  parameter int HOLD_STEPS      = 8
) (
  input  logic clk,
  input  logic reset,
  pong_if.game io
);

  localparam logic [3:0] PMAX  = 4'(GRID - PADDLE_LEN);
  localparam logic [3:0] PINIT = 4'(CENTER + 1 - PADDLE_LEN / 2);
  localparam logic [3:0] CPOS  = 4'(CENTER);

  logic        step;
  logic [3:0]  btn_meta, btn;
  logic [3:0]  lpos, rpos, lpos_n, rpos_n;
  logic [15:0] lmask, rmask;
  state_t      state;
  logic [3:0]  bx, by, by_n;
  logic        dx_neg, dy_neg, dy_neg_n, serve_neg;
  logic [7:0]  cnt;
  logic [3:0]  lscore, rscore;
  logic        at_left, at_right, lhit, rhit;

  pong_step_timer #(.FRAMES_PER_STEP(FRAMES_PER_STEP)) u_timer (
    .clk   (clk),
    .reset (reset),
    .vsync (io.vsync),
    .step  (step)
  );

  function automatic logic [3:0] next_pos(input logic [3:0] pos, input logic up, input logic down);
    logic [3:0] p;
    p = pos;
    if (up && !down && pos != 4'd0) p = pos - 4'd1;
    else if (down && !up && pos != PMAX) p = pos + 4'd1;
    return p;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  // btn = {lup, ldown, rup, rdown}
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= '0;
      btn      <= '0;
    end else begin
      btn_meta <= {io.lup, io.ldown, io.rup, io.rdown};
      btn      <= btn_meta;
    end
  end

  always_comb begin
    lpos_n   = next_pos(lpos, btn[3], btn[2]);
    rpos_n   = next_pos(rpos, btn[1], btn[0]);
    dy_neg_n = dy_neg;
    if ((by == 4'd0 && dy_neg) || (by == 4'd15 && !dy_neg)) dy_neg_n = ~dy_neg;
    by_n     = dy_neg_n ? by - 4'd1 : by + 4'd1;
    at_left  = (bx == 4'(LCOL)) && dx_neg;
    at_right = (bx == 4'(RCOL)) && !dx_neg;
    lhit     = lmask[by];
    rhit     = rmask[by];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lpos  <= PINIT;
      rpos  <= PINIT;
      lmask <= paddle_mask(PINIT, PADDLE_LEN);
      rmask <= paddle_mask(PINIT, PADDLE_LEN);
    end else if (step) begin
      lpos  <= lpos_n;
      rpos  <= rpos_n;
      lmask <= paddle_mask(lpos_n, PADDLE_LEN);
      rmask <= paddle_mask(rpos_n, PADDLE_LEN);
    end
  end

  // serve_neg remembers which side conceded last, so the next serve heads toward them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SERVE;
      bx        <= CPOS;
      by        <= CPOS;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      serve_neg <= 1'b0;
      cnt       <= '0;
      lscore    <= '0;
      rscore    <= '0;
    end else if (step) begin
      case (state)
        ST_SERVE: begin
          if (cnt == 8'(SERVE_STEPS - 1)) begin
            state  <= ST_PLAY;
            cnt    <= '0;
            dx_neg <= serve_neg;
            dy_neg <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_PLAY: begin
          by     <= by_n;
          dy_neg <= dy_neg_n;
          if (at_left) begin
            if (lhit) begin
              dx_neg <= 1'b0;
              bx     <= 4'(LCOL + 1);
            end else begin
              bx        <= 4'd0;
              rscore    <= sat_inc(rscore);
              serve_neg <= 1'b1;
              cnt       <= '0;
              state     <= ST_SCORED;
            end
          end else if (at_right) begin
            if (rhit) begin
              dx_neg <= 1'b1;
              bx     <= 4'(RCOL - 1);
            end else begin
              bx        <= 4'd15;
              lscore    <= sat_inc(lscore);
              serve_neg <= 1'b0;
              cnt       <= '0;
              state     <= ST_SCORED;
            end
          end else begin
            bx <= dx_neg ? bx - 4'd1 : bx + 4'd1;
          end
        end
        ST_SCORED: begin
          if (cnt == 8'(HOLD_STEPS - 1)) begin
            state <= ST_SERVE;
            cnt   <= '0;
            bx    <= CPOS;
            by    <= CPOS;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_SERVE;
      endcase
    end
  end

  assign io.ball_x  = bx;
  assign io.ball_y  = by;
  assign io.lpaddle = lmask;
  assign io.rpaddle = rmask;
  assign io.lscore  = lscore;
  assign io.rscore  = rscore;
  assign io.step    = step;
  assign io.state   = state;

endmodule

// File: tb/tb_pong_game.sv
// Directed + randomized bench for pong_game against a rule-level reference model.
module tb_pong_game;
  import pong_pkg::*;

  localparam int FPS = 4;
  localparam int PL  = 4;
  localparam int SS  = 8;
  localparam int HS  = 8;
  localparam int W   = 48;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pong_if io ();
  pong_if io1 ();

  pong_game #(.FRAMES_PER_STEP(FPS), .PADDLE_LEN(PL), .SERVE_STEPS(SS), .HOLD_STEPS(HS)) dut (
    .clk(clk), .reset(reset), .io(io)
  );
  pong_game #(.FRAMES_PER_STEP(1), .PADDLE_LEN(PL), .SERVE_STEPS(SS), .HOLD_STEPS(HS)) dut1 (
    .clk(clk), .reset(reset), .io(io1)
  );

  assign io1.vsync = io.vsync;
  assign io1.lup   = 1'b0;
  assign io1.ldown = 1'b0;
  assign io1.rup   = 1'b0;
  assign io1.rdown = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_step = 0;
  int n_step1 = 0;
  int n_rise = 0;

  always @(posedge clk) begin
    if (io.step)  n_step++;
    if (io1.step) n_step1++;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: plain integers, directions are +1/-1
  int m_bx, m_by, m_dx, m_dy, m_lp, m_rp, m_ls, m_rs, m_phase, m_cnt, m_serve;
  int n_hit, n_miss, n_corner;

  function automatic logic [15:0] mask_of(input int p);
    logic [15:0] m;
    for (int r = 0; r < 16; r++) m[r] = (r >= p) && (r < p + PL);
    return m;
  endfunction

  function automatic int move(input int p, input bit up, input bit dn);
    int q;
    q = p;
    if (up && !dn) q = p - 1;
    if (dn && !up) q = p + 1;
    if (q < 0) q = 0;
    if (q > 16 - PL) q = 16 - PL;
    return q;
  endfunction

  function automatic state_t phase_state(input int ph);
    return (ph == 0) ? ST_SERVE : (ph == 1) ? ST_PLAY : ST_SCORED;
  endfunction

  task automatic model_reset();
    m_bx = 7; m_by = 7; m_dx = 1; m_dy = 1;
    m_lp = 8 - PL / 2; m_rp = 8 - PL / 2;
    m_ls = 0; m_rs = 0; m_phase = 0; m_cnt = 0; m_serve = 1;
  endtask

  task automatic model_step(input bit lu, input bit ld, input bit ru, input bit rd);
    logic [15:0] lm, rm;
    int by0;
    bit ybounce, xbounce;
    lm = mask_of(m_lp);
    rm = mask_of(m_rp);
    by0 = m_by;
    if (m_phase == 0) begin
      m_cnt++;
      if (m_cnt == SS) begin
        m_phase = 1; m_cnt = 0; m_dx = m_serve; m_dy = 1;
      end
    end else if (m_phase == 1) begin
      ybounce = (m_by == 0 && m_dy < 0) || (m_by == 15 && m_dy > 0);
      if (ybounce) m_dy = -m_dy;
      m_by = m_by + m_dy;
      xbounce = 1'b0;
      if (m_bx == 1 && m_dx < 0) begin
        if (lm[by0]) begin m_dx = 1; m_bx = 2; n_hit++; xbounce = 1'b1; end
        else begin
          m_bx = 0; m_rs = (m_rs < 15) ? m_rs + 1 : 15;
          m_phase = 2; m_cnt = 0; m_serve = -1; n_miss++;
        end
      end else if (m_bx == 14 && m_dx > 0) begin
        if (rm[by0]) begin m_dx = -1; m_bx = 13; n_hit++; xbounce = 1'b1; end
        else begin
          m_bx = 15; m_ls = (m_ls < 15) ? m_ls + 1 : 15;
          m_phase = 2; m_cnt = 0; m_serve = 1; n_miss++;
        end
      end else begin
        m_bx = m_bx + m_dx;
      end
      if (ybounce && xbounce) n_corner++;
    end else begin
      m_cnt++;
      if (m_cnt == HS) begin
        m_phase = 0; m_cnt = 0; m_bx = 7; m_by = 7;
      end
    end
    m_lp = move(m_lp, lu, ld);
    m_rp = move(m_rp, ru, rd);
    exp_q.push_back({4'(m_bx), 4'(m_by), mask_of(m_lp), mask_of(m_rp), 4'(m_ls), 4'(m_rs)});
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {io.ball_x, io.ball_y, io.lpaddle, io.rpaddle, io.lscore, io.rscore};
  endfunction

  // driver: FPS vsync pulses (2 high, 2 low); outputs settle 2 cycles after the last rise
  task automatic do_step(input bit lu, input bit ld, input bit ru, input bit rd, input string tag);
    int s0;
    logic [W-1:0] e;
    @(negedge clk);
    io.lup = lu; io.ldown = ld; io.rup = ru; io.rdown = rd;
    s0 = n_step;
    for (int f = 0; f < FPS; f++) begin
      @(negedge clk); io.vsync = 1'b1; n_rise++;
      @(negedge clk);
      chk({tag, "_step_pulse"}, 64'(io.step), 64'(f == FPS - 1));
      io.vsync = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    model_step(lu, ld, ru, rd);
    e = exp_q.pop_front();
    chk({tag, "_outputs"}, 64'(dut_vec()), 64'(e));
    chk({tag, "_state"}, 64'(io.state), 64'(phase_state(m_phase)));
    chk({tag, "_step_count"}, 64'(n_step - s0), 64'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_outputs"}, 64'(dut_vec()), 64'({4'd7, 4'd7, 16'h03C0, 16'h03C0, 4'd0, 4'd0}));
    chk({tag, "_step"}, 64'(io.step), 64'd0);
    chk({tag, "_state"}, 64'(io.state), 64'(ST_SERVE));
  endtask

  initial begin
    int guard, extra, miss0;
    bit lu, ld, ru, rd;
    io.vsync = 1'b0; io.lup = 1'b0; io.ldown = 1'b0; io.rup = 1'b0; io.rdown = 1'b0;
    n_hit = 0; n_miss = 0; n_corner = 0;
    model_reset();

    // reset
    repeat (3) @(negedge clk);
    #1 chk_reset_values("in_reset");
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_values("after_release");

    // serve hold, then launch toward the right and down
    for (int i = 0; i < SS; i++) do_step(0, 0, 0, 0, "serve");
    chk("serve_hold_ball", 64'({io.ball_x, io.ball_y}), 64'h77);
    do_step(0, 0, 0, 0, "launch");
    chk("launch_ball", 64'({io.ball_x, io.ball_y}), 64'h88);

    // paddle clamp at the top, then both buttons hold still
    for (int i = 0; i < 10; i++) do_step(1, 0, 0, 0, "lclamp");
    chk("lpaddle_clamp_top", 64'(io.lpaddle), 64'h000F);
    do_step(1, 1, 0, 0, "lboth");
    chk("lpaddle_both", 64'(io.lpaddle), 64'h000F);
    for (int i = 0; i < 12; i++) do_step(0, 0, 0, 1, "rclamp");
    chk("rpaddle_clamp_bottom", 64'(io.rpaddle), 64'hF000);

    // randomized play: left random, right mostly tracks the ball
    for (int i = 0; i < 400; i++) begin
      lu = 1'($urandom_range(0, 1)); ld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        ru = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      end else begin
        ru = (m_by < m_rp + 1); rd = (m_by > m_rp + 2);
      end
      do_step(lu, ld, ru, rd, "rand");
    end

    // left parks at the top so the right side keeps scoring until it saturates
    guard = 0; extra = 0;
    while ((m_rs < 15 || extra < 3) && guard < 1500) begin
      miss0 = m_rs;
      do_step(1, 0, (m_by < m_rp + 1), (m_by > m_rp + 2), "sat");
      if (m_rs == 15 && miss0 == 15 && m_phase == 2 && m_cnt == 0 && m_bx == 0) extra++;
      guard++;
    end
    chk("rscore_saturated", 64'(io.rscore), 64'd15);

    // reset mid-play restores everything immediately
    guard = 0;
    while (m_phase != 1 && guard < 40) begin
      do_step(0, 0, 0, 0, "to_play");
      guard++;
    end
    chk("reached_play", 64'(io.state), 64'(ST_PLAY));
    do_step(0, 1, 1, 0, "mid_play");
    @(negedge clk); reset = 1'b0;
    #1 chk_reset_values("mid_reset");
    repeat (2) @(negedge clk); reset = 1'b1;
    model_reset();
    for (int i = 0; i < SS + 3; i++) do_step(0, 0, 0, 0, "post_reset");

    // divide-by-one instance: one step per vsync rise
    repeat (4) @(negedge clk);
    chk("fps1_step_per_rise", 64'(n_step1), 64'(n_rise));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("model events: hits=%0d misses=%0d corners=%0d", n_hit, n_miss, n_corner);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_game.md
# pong_game

Game-state controller for the pong display path. Advances ball and paddle state once per game step, with steps derived from the VGA vertical sync. Drives the 16×16-cell `ball_x`/`ball_y` and `lpaddle`/`rpaddle` column masks consumed by the VGA renderer, plus per-player scores. All outputs are registered and change only on a step, so the renderer never sees a mid-frame update.

## Interface

- `FRAMES_PER_STEP`, 4: frames per game step (≥1).
- `PADDLE_LEN`, 4: paddle height in cells (1..15).
- `SERVE_STEPS`, 8: steps the ball rests at centre before launch.
- `HOLD_STEPS`, 8: steps the ball rests in the goal column after a miss.

Ports:

- `clk` in 1: pixel clock, same domain as the sync generator.
- `reset` in 1: asynchronous, active-low reset.
- `vsync` in 1: vertical sync from the sync generator. A frame starts on its 0→1 transition.
- `lup`, `ldown`, `rup`, `rdown` in 1 each: raw button levels, asynchronous.
- `ball_x`, `ball_y` out 4: ball cell.
- `lpaddle`, `rpaddle` out 16: bit *i* set means cell row *i* is occupied by the paddle.
- `lscore`, `rscore` out 4: scores, saturating at 15.
- `step` out 1: one-cycle pulse marking a game step.

## Operation

- **Buttons**: each button passes through a 2-FF synchronizer and is sampled only at `step`.
- **Paddles**: each paddle holds a position register `p` in 0..16−`PADDLE_LEN`. The mask is `PADDLE_LEN` ones starting at bit `p`.
  - up and not down: `p` decrements.
  - down and not up: `p` increments.
  - both or neither: no move.
  - Movement clamps at the limits, no wrap.
  - Paddles move in every state.
- **Ball direction**: `dx` and `dy` are each ±1.
- **FSM states**: SERVE, PLAY, SCORED.
- **SERVE**: ball held at (7,7); a step counter runs. After `SERVE_STEPS` steps, go to PLAY. `dx` points toward the player who last conceded (+1 after reset); `dy` = +1.
- **PLAY**, each step:
  - **Y axis**: if `ball_y`=0 and `dy`=−1, or `ball_y`=15 and `dy`=+1, negate `dy` and move one cell the other way. Otherwise `ball_y` += `dy`.
  - **X axis, left edge** (`ball_x`=1, `dx`=−1):
    - If `lpaddle[ball_y]` is set (current `ball_y` and pre-step mask), `dx` becomes +1 and `ball_x` becomes 2.
    - Otherwise `ball_x` becomes 0, `rscore` increments (saturating), and the FSM goes to SCORED.
  - **X axis, right edge**: mirrored at `ball_x`=14 with `rpaddle`, column 15 and `lscore`.
  - **Otherwise**: `ball_x` += `dx`.
  - X and Y are resolved independently in the same step, so corner hits bounce on both axes.
- **SCORED**: ball frozen in the goal column. After `HOLD_STEPS` steps, go to SERVE with the step counter cleared.
- **Reset values**:
  - Outputs: `ball_x`=7, `ball_y`=7, `lscore`=`rscore`=0, `step`=0.
  - Internal: state SERVE, `dx`=+1, `dy`=+1, step counter 0, frame counter 0.
  - Paddle positions (8−`PADDLE_LEN`/2), giving masks 16'h03C0 for the default `PADDLE_LEN`.
- Reset asserted mid-game restores all of the above asynchronously. The first `step` after release needs `FRAMES_PER_STEP` full vsync rises.

## Timing

- A vsync edge detector (one register) produces `frame` in the cycle after the 0→1 transition.
- The frame counter counts 0..`FRAMES_PER_STEP`−1. `step` is asserted the cycle after `frame` with counter = `FRAMES_PER_STEP`−1; the counter wraps to 0 at that point.
- Ball, paddle, score and FSM registers update on the clock edge ending the `step` cycle. Output latency is 2 cycles from the vsync rise.
- A button change must be stable for 2 clocks plus the time until the next `step` to take effect.
- All step-boundary decisions (hit/miss, bounce) use register values from before that step.

## Structure

- **Package `pong_pkg`**: FSM state enum, `GRID`=16, `CENTER`=7, `LCOL`=1, `RCOL`=14, and a function that builds a paddle mask from a position and length.
- **Sub-module `pong_step_timer`**: vsync edge detector and frame divider, outputting `step`. It is parameterized by `FRAMES_PER_STEP`.
- Button synchronizers, paddle logic, ball logic and FSM stay in `pong_game`.

## Test plan

1. **Reset**: release `reset`, no buttons → ball (7,7), masks 16'h03C0, scores 0. After 8 steps ball is still (7,7); step 9 gives (8,8).
2. **Paddle clamp**: hold `lup` for 10 steps → `lpaddle` = 16'h000F. Hold both `lup` and `ldown` → mask unchanged.
3. **Paddle hit**: ball at (1,5), `dx`=−1, `lpaddle` covers rows 4..7 → next step ball (2,…), `dx`=+1, `rscore` unchanged.
4. **Miss**: same as scenario 3 with `lpaddle`=16'hF000 → ball (0,…), `rscore`=1, FSM SCORED. After 8 steps the ball returns to (7,7) and then launches with `dx`=−1.
5. **Corner**: ball (14,15), `dx`=+1, `dy`=+1, `rpaddle[15]` set → next step (13,14) with both directions negated.
6. **Divider and saturation**: `FRAMES_PER_STEP`=1 gives exactly one `step` per vsync rise. Force 16 right misses → `rscore` stays 15. Assert `reset` mid-PLAY → all outputs return to reset values immediately.
